ssy_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one ssy resource among N requesters.
- The ssy resource is single-request, with an idle/request/granted interface.
- Collects level requests, forwards one single-cycle request to ssy only when ssy reports idle, waits for granted, then returns a one-cycle ack to the winner.
- Sits between client blocks and the ssy instance; replaces the ad-hoc "request only when idle" gating done at the top level.

---
 rtl/ssy_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ssy_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssy_rr_arbiter.sv
// rtl/ssy_rr_arbiter.sv - round-robin arbiter sharing one single-request ssy resource
//
// Collects level requests from N clients and forwards one single-cycle request
// to ssy, only while ssy reports idle. It then waits for ssy to grant and
// returns a one-cycle ack to the winner. If ssy does not grant within TIMEOUT
// WAIT cycles, the transaction is abandoned and flagged with a timeout pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req[N]       per-requester level request
//   ack[N]       one-hot one-cycle pulse: winner's transaction was granted
//   res_idle     ssy idle (sampled only while arbitrating)
//   res_request  one-cycle request pulse to ssy
//   res_granted  ssy granted
//   busy         transaction in flight
//   owner[IDW]   current winner index, valid while busy
//   timeout      one-cycle pulse: ssy did not grant in time
//   err_id[IDW]  winner index captured on the last timeout
module ssy_rr_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   ack,
    input  logic           res_idle,
    output logic           res_request,
    input  logic           res_granted,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           timeout,
    output logic [IDW-1:0] err_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           res_request_q, res_request_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           timeout_q, timeout_d;
    logic [IDW-1:0] err_id_q, err_id_d;

    // Rotating-priority search: first set bit of req starting at ptr,
    // wrapping mod N. ptr+i never exceeds 2N-2, so a single conditional
    // subtract is enough to wrap and one extra bit holds the sum.
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   scan_pos;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = '0;
        for (int i = 0; i < N; i++) begin
            scan_pos = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan_pos >= (IDW+1)'(N)) begin
                scan_pos = scan_pos - (IDW+1)'(N);
            end
            if (!win_found && req[scan_pos[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_pos[IDW-1:0];
            end
        end
    end

    // Pointer always moves past the owner just served or timed out.
    logic [IDW-1:0] owner_next;

    always_comb begin
        owner_next = '0;
        if (owner_q != IDW'(N-1)) begin
            owner_next = owner_q + IDW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        res_request_d = res_request_q;
        busy_d        = busy_q;
        owner_d       = owner_q;
        timeout_d     = 1'b0;
        err_id_d      = err_id_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found && res_idle) begin
                    owner_d       = win_idx;
                    busy_d        = 1'b1;
                    res_request_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // ssy never grants in the request cycle, so res_granted is not looked at here.
                res_request_d = 1'b0;
                cnt_d         = '0;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A grant arriving on the last allowed cycle still counts.
                if (res_granted) begin
                    ack_d[owner_q] = 1'b1;
                    ptr_d          = owner_next;
                    state_d        = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    timeout_d = 1'b1;
                    err_id_d  = owner_q;
                    ptr_d     = owner_next;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Gap cycle lets the acked requester drop req before the next sample.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            res_request_q <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= '0;
            timeout_q     <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            res_request_q <= res_request_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            timeout_q     <= timeout_d;
            err_id_q      <= err_id_d;
        end
    end

    assign ack         = ack_q;
    assign res_request = res_request_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout     = timeout_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_ssy_rr_arbiter.sv
// tb/tb_ssy_rr_arbiter.sv - self-checking bench for ssy_rr_arbiter
module tb_ssy_rr_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;
    localparam int VW      = N + 3 + 2*IDW;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N-1:0]   ack;
    logic           res_idle;
    logic           res_request;
    logic           res_granted;
    logic           busy;
    logic [IDW-1:0] owner;
    logic           timeout;
    logic [IDW-1:0] err_id;

    always #5 clk = ~clk;

    ssy_rr_arbiter #(
        .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .ack(ack),
        .res_idle(res_idle),
        .res_request(res_request),
        .res_granted(res_granted),
        .busy(busy),
        .owner(owner),
        .timeout(timeout),
        .err_id(err_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level reference: a transaction is identified by its age in
    // edges since the issue edge; ISSUE is age 1, grant/timeout windows are
    // ages 2..TIMEOUT+1, the close-out edge is one after resolution.
    bit           m_active;
    int           m_age;
    int           m_res;
    int           m_owner;
    int           m_ptr;
    int           m_err;
    logic [N-1:0] m_ack;
    bit           m_to;

    task automatic model_reset();
        m_active = 0; m_age = 0; m_res = 0; m_owner = 0;
        m_ptr = 0; m_err = 0; m_ack = '0; m_to = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic idle, input logic gr);
        bit found;
        m_ack = '0;
        m_to  = 0;
        if (!m_active) begin
            if (r != '0 && idle) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && r[(m_ptr + i) % N]) begin
                        found   = 1;
                        m_owner = (m_ptr + i) % N;
                    end
                end
                m_active = 1; m_age = 0; m_res = 0;
            end
        end else begin
            m_age++;
            if (m_res != 0) begin
                m_active = 0;
            end else if (m_age >= 2) begin
                if (gr) begin
                    m_ack[m_owner] = 1'b1;
                    m_res = m_age;
                    m_ptr = (m_owner + 1) % N;
                end else if (m_age == TIMEOUT + 1) begin
                    m_to  = 1;
                    m_err = m_owner;
                    m_res = m_age;
                    m_ptr = (m_owner + 1) % N;
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {ack, res_request, busy, owner, timeout, err_id};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic rr;
        rr = m_active && (m_age == 0);
        return {m_ack, rr, m_active, IDW'(m_owner), m_to, IDW'(m_err)};
    endfunction

    // Drive at negedge, advance one posedge, compare at the following negedge.
    task automatic cycle(input logic [N-1:0] r, input logic idle, input logic gr);
        req = r; res_idle = idle; res_granted = gr;
        @(posedge clk);
        model_step(r, idle, gr);
        @(negedge clk);
        check("cycle_vs_model", dut_vec(), model_vec());
    endtask

    task automatic do_reset_async();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_vec(), '0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct {
        logic [N-1:0]   req;
        logic           idle;
        logic           gr;
        logic [N-1:0]   e_ack;
        logic           e_rr;
        logic           e_busy;
        logic [IDW-1:0] e_owner;
    } vec_t;

    vec_t         tbl [10];
    int           order [$];
    logic [N-1:0] pending;
    logic [N-1:0] rnd_req;
    int           edges;
    int           to_edge;
    bit           ack_seen;

    initial begin
        // single request (grant k=2), then a requester dropping req mid-transaction
        tbl[0] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2};
        tbl[2] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2};
        tbl[3] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[5] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};
        tbl[6] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[8] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[9] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};

        reset_n = 1'b0; req = '0; res_idle = 1'b0; res_granted = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_vec(), '0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].req, tbl[i].idle, tbl[i].gr);
            check($sformatf("tbl%0d", i), {ack, res_request, busy, owner},
                  {tbl[i].e_ack, tbl[i].e_rr, tbl[i].e_busy, tbl[i].e_owner});
        end

        // idle gating: ptr=1, requester 0 waits for res_idle
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            check("idle_gate", {res_request, busy}, 2'b00);
        end
        cycle(4'b0001, 1'b1, 1'b0);
        check("idle_release", {res_request, busy, owner}, 4'b1100);
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);

        // reset during WAIT, ptr must restart at 0 (stale ptr=1 would pick 3)
        cycle(4'b0100, 1'b1, 1'b0);
        check("pre_reset_owner", owner, 2);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        do_reset_async();
        cycle(4'b1001, 1'b1, 1'b0);
        check("post_reset_winner", owner, 0);
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        check("post_reset_owner3", owner, 3);
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1);
        check("post_reset_ack3", ack, 4'b1000);
        cycle(4'b0000, 1'b1, 1'b0);

        // round robin, ptr=0, each requester drops after its ack
        pending = 4'b1111;
        edges = 0;
        while (order.size() < 4 && edges < 40) begin
            cycle(pending, 1'b1, 1'b1);
            if (ack != '0) begin
                order.push_back(onehot_idx(ack));
                pending = pending & ~ack;
            end
            edges++;
        end
        check("rr_all_count", order.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_all_order", (i < order.size()) ? order[i] : -1, i);

        // 0011 held continuously: re-arbitrated, alternates
        order.delete();
        edges = 0;
        while (order.size() < 4 && edges < 40) begin
            cycle(4'b0011, 1'b1, 1'b1);
            if (ack != '0) order.push_back(onehot_idx(ack));
            edges++;
        end
        check("rr_held_count", order.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_held_order", (i < order.size()) ? order[i] : -1, i % 2);
        cycle(4'b0000, 1'b1, 1'b0);

        // timeout: owner 1, ssy never grants
        cycle(4'b0010, 1'b1, 1'b0);
        check("to_owner", owner, 1);
        to_edge = -1; edges = 0; ack_seen = 0;
        while (to_edge < 0 && edges < 40) begin
            cycle(4'b0011, 1'b1, 1'b0);
            edges++;
            if (ack != '0) ack_seen = 1;
            if (timeout) to_edge = edges;
        end
        check("to_latency", to_edge, TIMEOUT + 1);
        check("to_err_id", err_id, 1);
        check("to_no_ack", ack_seen, 0);
        cycle(4'b0011, 1'b1, 1'b0);
        check("to_pulse_drop", timeout, 0);
        cycle(4'b0011, 1'b1, 1'b0);
        check("to_next_winner", owner, 0);

        // grant on the final WAIT cycle beats timeout
        for (int i = 0; i < TIMEOUT; i++) cycle(4'b0011, 1'b1, 1'b0);
        cycle(4'b0011, 1'b1, 1'b1);
        check("race_ack", ack, 4'b0001);
        check("race_timeout", timeout, 0);
        check("race_err_id", err_id, 1);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // randomized traffic against the model
        rnd_req = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) do_reset_async();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 3) != 0) rnd_req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    rnd_req[i] = ~rnd_req[i];
                end
            end
            cycle(rnd_req, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
